sigmoid_sweep_checker: RTL and testbench
========================================

Name: sigmoid_sweep_checker

Overview:
Self-checking sweep harness that sits around sigmoid_taylor. It drives x with every Q4.8 code and consumes the matching f_x result. It compares each f_x against an exact Q1.12 reference held in a synchronous ROM, and accumulates the absolute-error sum, the max error and the x code of the max error. It moves the exhaustive-accuracy check into synthesizable logic so the check can run on the board.

Parameters:
X_W, 12, input code width (Q4.8 signed)
Y_W, 13, result width (Q1.12 unsigned)
LATENCY, 1, clk cycles from x_out to valid f_x_in; legal range 1..8
ACC_W, 25, width of err_sum
SKIP_CODE, 12'h800, input code excluded from the sweep

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  begin sweep; sampled only in IDLE or DONE
busy  out  1  high while sweep or drain is in progress
done  out  1  one-cycle pulse when results are final
x_out  out  X_W  to sigmoid_taylor x
f_x_in  in  Y_W  from sigmoid_taylor f_x
ref_addr  out  X_W  reference ROM address; always equals x_out
ref_data  in  Y_W  reference ROM data, valid one cycle after ref_addr
err_sum  out  ACC_W  sum of |f_x_in - ref|, saturating
err_max  out  Y_W  largest |f_x_in - ref|
err_max_x  out  X_W  x code that produced err_max
sample_count  out  13  number of compared samples

Behaviour:
- Reset (async): state IDLE. All outputs 0: busy, done, x_out, err_sum, err_max, err_max_x, sample_count. Tag pipeline is cleared. This applies equally to a reset asserted mid-sweep.
- States:
  - IDLE: start=1 -> RUN. Accumulators, max and count clear on the same edge.
  - RUN: x_out steps one code per cycle: 0x000, 0x001, …, 0x7FF, 0x801, …, 0xFFF. SKIP_CODE is never driven; 4095 codes in total. After 0xFFF is issued -> DRAIN.
  - DRAIN: x_out holds 0xFFF. Wait until the tag pipeline is empty (LATENCY cycles) -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, results hold. start=1 -> RUN with clear. Otherwise the block stays in DONE with done=0 and results held.
- start is ignored while busy=1.
- Timing: start sampled at edge k gives x_out=0x000 and busy=1 from edge k. Last code is issued at edge k+4094. Last compare at edge k+4094+LATENCY. done=1 and busy=0 at edge k+4095+LATENCY.
- Alignment: a shift register of depth LATENCY carries a valid bit and the x code. ref_data is delayed LATENCY-1 cycles internally so it lines up with f_x_in at the tail.
- Compare, at the tail when valid:
  - diff = |f_x_in - ref_aligned| as a Y_W-bit unsigned value.
  - err_sum += diff, saturating at 2^ACC_W-1.
  - sample_count += 1.
  - If diff > err_max (strictly greater), update err_max and err_max_x. The first occurrence wins on ties.
- Results are registered and update in the cycle after the compare.
- x_out is 0x000 in IDLE.

Optional Feature:
SIGMOID_CHK_MEAN_EN
- Defined: adds output err_mean [Y_W-1:0] = saturate(err_sum >> 12), the team's divide-by-4096 mean. It is registered and valid from the done pulse onward. It is 0 on reset and on start.
- Undefined: the err_mean port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Loopback model (f_x_in = ROM value delayed LATENCY), LATENCY=1 -> err_sum=0, err_max=0, sample_count=4095, done pulse exactly 4096 cycles after start edge, busy low from that edge.
2. Offset model f_x = ref+3 -> err_sum=12285, err_max=3, err_max_x=0x000; with SIGMOID_CHK_MEAN_EN, err_mean=2.
3. Single spike: f_x = ref+100 only at x=0x123, exact elsewhere, LATENCY=3 -> err_sum=100, err_max=100, err_max_x=0x123, done at start+4098.
4. Sweep order monitor -> x_out never equals 0x800; 0x7FF is immediately followed by 0x801; last issued code is 0xFFF.
5. ACC_W=12, offset 2 -> err_sum saturates at 0xFFF (no wrap), sample_count=4095.
6. Assert reset at sample 1000 -> busy, x_out and all results are 0 asynchronously. A start pulse mid-sweep in a separate run is ignored, and that run's results are identical to an undisturbed run.

Source files
------------

// File: rtl/sigmoid_sweep_checker_if.sv
// sigmoid_sweep_checker_if: checker-side bus to sigmoid_taylor and its reference ROM.
interface sigmoid_sweep_checker_if #(
   parameter int X_W = 12,
   parameter int Y_W = 13
);
   logic [X_W-1:0] x_out;
   logic [X_W-1:0] ref_addr;
   logic [Y_W-1:0] f_x_in;
   logic [Y_W-1:0] ref_data;
   modport master (output x_out, ref_addr, input f_x_in, ref_data);
   modport slave (input x_out, ref_addr, output f_x_in, ref_data);
endinterface

// File: rtl/sigmoid_sweep_checker.sv
// sigmoid_sweep_checker: exhaustive Q4.8 sweep of sigmoid_taylor against a reference ROM.
// Define SIGMOID_CHK_MEAN_EN to add the registered err_mean output.
module sigmoid_sweep_checker #(
   parameter int X_W = 12,
   parameter int Y_W = 13,
   parameter int LATENCY = 1,
   parameter int ACC_W = 25,
   parameter logic [X_W-1:0] SKIP_CODE = 12'h800
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done,
   sigmoid_sweep_checker_if.master bus,
   output logic [ACC_W-1:0] err_sum,
   output logic [Y_W-1:0] err_max,
   output logic [X_W-1:0] err_max_x,
`ifdef SIGMOID_CHK_MEAN_EN
   output logic [12:0] sample_count,
   output logic [Y_W-1:0] err_mean
`else
   output logic [12:0] sample_count
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam int SW = (ACC_W > Y_W ? ACC_W : Y_W) + 1;
   state_t state_q, state_d;
   logic [X_W-1:0] x_q, x_d, x_inc, maxx_q, maxx_d;
   logic [LATENCY-1:0] vld_q, vld_d;
   logic [X_W-1:0] tx_q [LATENCY];
   logic [X_W-1:0] tx_d [LATENCY];
   logic [Y_W-1:0] ref_al, diff, max_q, max_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [SW-1:0] sum_w;
   logic [12:0] cnt_q, cnt_d;
   logic done_q, done_d, go, hit;
   assign go = (state_q == IDLE || state_q == DONE) && start;
   assign hit = vld_q[LATENCY-1];
   assign x_inc = x_q + 1'b1;
   assign diff = bus.f_x_in >= ref_al ? bus.f_x_in - ref_al : ref_al - bus.f_x_in;
   assign sum_w = SW'(sum_q) + SW'(diff);
   assign bus.x_out = x_q;
   assign bus.ref_addr = x_q;
   assign busy = state_q == RUN || state_q == DRAIN;
   assign done = done_q;
   assign err_sum = sum_q;
   assign err_max = max_q;
   assign err_max_x = maxx_q;
   assign sample_count = cnt_q;
   // ROM data arrives one cycle after its address; delay the rest of the way to meet f_x_in.
   if (LATENCY == 1) begin : g_ref
      assign ref_al = bus.ref_data;
   end else begin : g_ref
      logic [Y_W-1:0] rs_q [LATENCY-1];
      logic [Y_W-1:0] rs_d [LATENCY-1];
      always_comb begin
         rs_d[0] = bus.ref_data;
         for (int i = 1; i < LATENCY - 1; i++) rs_d[i] = rs_q[i-1];
      end
      always_ff @(posedge clk or posedge reset)
         if (reset) rs_q <= '{default: '0};
         else rs_q <= rs_d;
      assign ref_al = rs_q[LATENCY-2];
   end
   always_comb begin
      state_d = state_q;
      x_d = x_q;
      vld_d[0] = state_q == RUN;
      tx_d[0] = x_q;
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         tx_d[i] = tx_q[i-1];
      end
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = RUN;
            x_d = '0;
         end
         RUN: if (&x_q) state_d = DRAIN;
              else x_d = x_inc == SKIP_CODE ? x_inc + 1'b1 : x_inc;
         DRAIN: if (vld_d == '0) state_d = DONE;
         default: state_d = IDLE;
      endcase
      done_d = state_q == DRAIN && vld_d == '0;
      sum_d = go ? '0 : hit ? (sum_w > SW'({ACC_W{1'b1}}) ? '1 : sum_w[ACC_W-1:0]) : sum_q;
      cnt_d = go ? '0 : cnt_q + 13'(hit);
      {max_d, maxx_d} = go ? '0 : (hit && diff > max_q) ? {diff, tx_q[LATENCY-1]} : {max_q, maxx_q};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         x_q <= '0;
         vld_q <= '0;
         tx_q <= '{default: '0};
         sum_q <= '0;
         max_q <= '0;
         maxx_q <= '0;
         cnt_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q <= x_d;
         vld_q <= vld_d;
         tx_q <= tx_d;
         sum_q <= sum_d;
         max_q <= max_d;
         maxx_q <= maxx_d;
         cnt_q <= cnt_d;
         done_q <= done_d;
      end
`ifdef SIGMOID_CHK_MEAN_EN
   logic [Y_W-1:0] mean_q, mean_d;
   logic [SW-1:0] mean_w;
   // Mean over the sweep is sum/4096, latched alongside the done pulse.
   always_comb begin
      mean_w = SW'(sum_d >> 12);
      mean_d = go ? '0 : done_d ? (mean_w > SW'({Y_W{1'b1}}) ? '1 : mean_w[Y_W-1:0]) : mean_q;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) mean_q <= '0;
      else mean_q <= mean_d;
   assign err_mean = mean_q;
`endif
endmodule

// File: tb/tb_sigmoid_sweep_checker.sv
// tb_sigmoid_sweep_checker: two checkers (LATENCY=1/ACC_W=25, LATENCY=3/ACC_W=12) driven by
// behavioural sigmoid/ROM stand-ins with per-code error tables, checked against a sweep model.
module tb_sigmoid_sweep_checker;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_s [2];
   logic busy0, busy1, done0, done1;
   logic [24:0] sum0;
   logic [11:0] sum1, mxx0, mxx1;
   logic [12:0] max0, max1, cnt0, cnt1;
   logic busy_w [2];
   logic done_w [2];
   logic [11:0] x_w [2];
   logic [11:0] ra_w [2];
   logic [11:0] mxx_w [2];
   logic [24:0] sum_w [2];
   logic [12:0] max_w [2];
   logic [12:0] cnt_w [2];
   logic [12:0] fp0 [8];
   logic [12:0] fp1 [8];
   int rom [4096];
   int err_tab [2][4096];
   int n_cmp = 0;
   int n_bad = 0;
`ifdef SIGMOID_CHK_MEAN_EN
   logic [12:0] mean0, mean1;
`endif
   sigmoid_sweep_checker_if #(.X_W(12), .Y_W(13)) bus0 ();
   sigmoid_sweep_checker_if #(.X_W(12), .Y_W(13)) bus1 ();
   sigmoid_sweep_checker #(.LATENCY(1), .ACC_W(25)) u0 (
      .clk(clk), .reset(reset), .start(start_s[0]), .busy(busy0), .done(done0), .bus(bus0.master),
      .err_sum(sum0), .err_max(max0), .err_max_x(mxx0),
`ifdef SIGMOID_CHK_MEAN_EN
      .sample_count(cnt0), .err_mean(mean0)
`else
      .sample_count(cnt0)
`endif
   );
   sigmoid_sweep_checker #(.LATENCY(3), .ACC_W(12)) u1 (
      .clk(clk), .reset(reset), .start(start_s[1]), .busy(busy1), .done(done1), .bus(bus1.master),
      .err_sum(sum1), .err_max(max1), .err_max_x(mxx1),
`ifdef SIGMOID_CHK_MEAN_EN
      .sample_count(cnt1), .err_mean(mean1)
`else
      .sample_count(cnt1)
`endif
   );
   assign busy_w[0] = busy0;
   assign busy_w[1] = busy1;
   assign done_w[0] = done0;
   assign done_w[1] = done1;
   assign x_w[0] = bus0.x_out;
   assign x_w[1] = bus1.x_out;
   assign ra_w[0] = bus0.ref_addr;
   assign ra_w[1] = bus1.ref_addr;
   assign mxx_w[0] = mxx0;
   assign mxx_w[1] = mxx1;
   assign sum_w[0] = sum0;
   assign sum_w[1] = {13'd0, sum1};
   assign max_w[0] = max0;
   assign max_w[1] = max1;
   assign cnt_w[0] = cnt0;
   assign cnt_w[1] = cnt1;
   assign bus0.f_x_in = fp0[0];
   assign bus1.f_x_in = fp1[2];
   always #5 clk = ~clk;
   // Stand-ins: registered ROM, and a sigmoid whose result is ROM value plus the code's error.
   always @(posedge clk) begin
      bus0.ref_data <= 13'(rom[bus0.ref_addr]);
      bus1.ref_data <= 13'(rom[bus1.ref_addr]);
      fp0[0] <= 13'(rom[bus0.x_out] + err_tab[0][bus0.x_out]);
      fp1[0] <= 13'(rom[bus1.x_out] + err_tab[1][bus1.x_out]);
      for (int i = 1; i < 8; i++) begin
         fp0[i] <= fp0[i-1];
         fp1[i] <= fp1[i-1];
      end
   end
   function automatic void model(input int d, output longint s, output int m, output int mx, output int c);
      longint cap = d ? 64'd4095 : 64'd33554431;
      s = 0;
      m = 0;
      mx = 0;
      c = 0;
      for (int k = 0; k < 4096; k++) begin
         int a;
         if (k == 2048) continue;
         a = err_tab[d][k] < 0 ? -err_tab[d][k] : err_tab[d][k];
         s = s + a > cap ? cap : s + a;
         if (a > m) begin
            m = a;
            mx = k;
         end
         c++;
      end
   endfunction
   task automatic fill_err(input int d, input int lo, input int hi);
      for (int k = 0; k < 4096; k++) err_tab[d][k] = lo + int'($urandom_range(hi - lo));
   endtask
   task automatic run_sweep(input int d, input int poke, output int cyc, output bit ord_ok, output bit busy_ok);
      logic [11:0] ex;
      int n;
      @(negedge clk);
      start_s[d] = 1'b1;
      @(negedge clk);
      start_s[d] = 1'b0;
      ex = 12'h000;
      ord_ok = 1'b1;
      busy_ok = 1'b1;
      n = 0;
      while (done_w[d] !== 1'b1 && n < 5000) begin
         if (n < 4095) begin
            if (x_w[d] !== ex || ra_w[d] !== ex || x_w[d] === 12'h800) ord_ok = 1'b0;
            ex = ex == 12'h7ff ? 12'h801 : ex + 12'd1;
         end else if (x_w[d] !== 12'hfff || ra_w[d] !== 12'hfff) ord_ok = 1'b0;
         if (busy_w[d] !== 1'b1) busy_ok = 1'b0;
         start_s[d] = n == poke;
         @(negedge clk);
         n++;
      end
      start_s[d] = 1'b0;
      cyc = n;
   endtask
   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({busy0, done0, bus0.x_out, sum0, max0, mxx0, cnt0} !== '0) begin
         n_bad++;
         $display("FAIL reset_u0 got %0h exp 0", {busy0, done0, bus0.x_out, sum0, max0, mxx0, cnt0});
      end
      n_cmp++;
      if ({busy1, done1, bus1.x_out, sum1, max1, mxx1, cnt1} !== '0) begin
         n_bad++;
         $display("FAIL reset_u1 got %0h exp 0", {busy1, done1, bus1.x_out, sum1, max1, mxx1, cnt1});
      end
      reset = 1'b0;
   endtask
   task automatic test_loopback();
      int cyc;
      bit o, b;
      fill_err(0, 0, 0);
      run_sweep(0, -1, cyc, o, b);
      n_cmp++;
      if (cyc !== 4096) begin n_bad++; $display("FAIL loop_done_cycle got %0d exp 4096", cyc); end
      n_cmp++;
      if (busy0 !== 1'b0) begin n_bad++; $display("FAIL loop_busy_at_done got %0b exp 0", busy0); end
      n_cmp++;
      if (!o) begin n_bad++; $display("FAIL loop_sweep_order got bad exp ordered"); end
      n_cmp++;
      if (!b) begin n_bad++; $display("FAIL loop_busy_during got low exp high"); end
      n_cmp++;
      if ({sum0, max0} !== '0) begin n_bad++; $display("FAIL loop_err got %0h/%0h exp 0/0", sum0, max0); end
      n_cmp++;
      if (cnt0 !== 13'd4095) begin n_bad++; $display("FAIL loop_count got %0d exp 4095", cnt0); end
      @(negedge clk);
      n_cmp++;
      if (done0 !== 1'b0 || cnt0 !== 13'd4095) begin
         n_bad++;
         $display("FAIL loop_done_hold got done=%0b cnt=%0d exp done=0 cnt=4095", done0, cnt0);
      end
   endtask
   task automatic test_offset();
      int cyc;
      bit o, b;
      fill_err(0, 3, 3);
      run_sweep(0, -1, cyc, o, b);
      n_cmp++;
      if (sum0 !== 25'd12285) begin n_bad++; $display("FAIL offs_sum got %0d exp 12285", sum0); end
      n_cmp++;
      if (max0 !== 13'd3 || mxx0 !== 12'h000) begin
         n_bad++;
         $display("FAIL offs_max got %0d@%0h exp 3@0", max0, mxx0);
      end
`ifdef SIGMOID_CHK_MEAN_EN
      n_cmp++;
      if (mean0 !== 13'd2) begin n_bad++; $display("FAIL offs_mean got %0d exp 2", mean0); end
`endif
   endtask
   task automatic test_spike();
      int cyc;
      bit o, b;
      fill_err(1, 0, 0);
      err_tab[1][12'h123] = 100;
      run_sweep(1, -1, cyc, o, b);
      n_cmp++;
      if (cyc !== 4098) begin n_bad++; $display("FAIL spike_done_cycle got %0d exp 4098", cyc); end
      n_cmp++;
      if (!o || !b) begin n_bad++; $display("FAIL spike_order_busy got %0b%0b exp 11", o, b); end
      n_cmp++;
      if (sum1 !== 12'd100 || max1 !== 13'd100 || mxx1 !== 12'h123) begin
         n_bad++;
         $display("FAIL spike_result got %0d/%0d@%0h exp 100/100@123", sum1, max1, mxx1);
      end
   endtask
   task automatic test_saturate();
      int cyc;
      bit o, b;
      fill_err(1, 2, 2);
      run_sweep(1, -1, cyc, o, b);
      n_cmp++;
      if (sum1 !== 12'hfff) begin n_bad++; $display("FAIL sat_sum got %0h exp fff", sum1); end
      n_cmp++;
      if (cnt1 !== 13'd4095) begin n_bad++; $display("FAIL sat_count got %0d exp 4095", cnt1); end
   endtask
   task automatic test_random(input int d, input int poke);
      int cyc, m, mx, c;
      longint s;
      bit o, b;
      fill_err(d, -40, 40);
      for (int k = 0; k < 4; k++) err_tab[d][$urandom_range(4095)] = 60 - 120 * int'($urandom_range(1));
      model(d, s, m, mx, c);
      run_sweep(d, poke, cyc, o, b);
      n_cmp++;
      if (cyc !== 4095 + (d ? 3 : 1)) begin n_bad++; $display("FAIL rnd%0d_cycle got %0d exp %0d", d, cyc, 4095 + (d ? 3 : 1)); end
      n_cmp++;
      if (!o || !b) begin n_bad++; $display("FAIL rnd%0d_order_busy got %0b%0b exp 11", d, o, b); end
      n_cmp++;
      if (sum_w[d] !== 25'(s)) begin n_bad++; $display("FAIL rnd%0d_sum got %0d exp %0d", d, sum_w[d], s); end
      n_cmp++;
      if (max_w[d] !== 13'(m) || mxx_w[d] !== 12'(mx)) begin
         n_bad++;
         $display("FAIL rnd%0d_max got %0d@%0h exp %0d@%0h", d, max_w[d], mxx_w[d], m, mx);
      end
      n_cmp++;
      if (cnt_w[d] !== 13'(c)) begin n_bad++; $display("FAIL rnd%0d_count got %0d exp %0d", d, cnt_w[d], c); end
`ifdef SIGMOID_CHK_MEAN_EN
      if (d == 0) begin
         n_cmp++;
         if (mean0 !== 13'(s >> 12)) begin n_bad++; $display("FAIL rnd_mean got %0d exp %0d", mean0, s >> 12); end
      end
`endif
   endtask
   task automatic test_reset_mid();
      fill_err(0, 5, 20);
      @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (1000) @(negedge clk);
      n_cmp++;
      if (busy0 !== 1'b1 || sum0 == '0) begin
         n_bad++;
         $display("FAIL mid_pre_reset got busy=%0b sum=%0d exp busy=1 sum>0", busy0, sum0);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({busy0, done0, bus0.x_out, sum0, max0, mxx0, cnt0} !== '0) begin
         n_bad++;
         $display("FAIL mid_async_reset got %0h exp 0", {busy0, done0, bus0.x_out, sum0, max0, mxx0, cnt0});
      end
      @(negedge clk);
      reset = 1'b0;
   endtask
   initial begin
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
      for (int k = 0; k < 4096; k++) rom[k] = 200 + int'($urandom_range(3600));
      test_reset();
      test_loopback();
      test_offset();
      test_spike();
      test_saturate();
      test_random(0, -1);
      test_random(1, -1);
      test_random(0, 1500);
      test_random(1, 4095);
      test_reset_mid();
      test_random(0, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
